// File: rtl/div_detector_pkg.sv
// Shared types and default sizing for the divided-clock detector.
package div_detector_pkg;

  // Default sizing: 7-bit divider, 8-bit half-period counter, 4 matches to lock.
  localparam int DIV_W_DEF      = 7;
  localparam int CNT_W_DEF      = 8;
  localparam int LOCK_COUNT_DEF = 4;

  // Counter saturation value (timeout) and largest legal half-period.
  localparam int CNT_MAX = (2 ** CNT_W_DEF) - 1;
  localparam int H_MAX   = 2 ** DIV_W_DEF;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FIRST,
    S_TRACK,
    S_LOCKED
  } state_t;

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer for an asynchronous square wave, plus one delay flop
// so that any change of the synchronized level yields a single-cycle pulse.
module sync_edge_det
  import div_detector_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic sig_in,
  output logic edge_pulse
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;
  logic dly_q, dly_d;

  // Shift the input through the synchronizer and delay stages.
  always_comb begin
    s1_d  = sig_in;
    s2_d  = s1_q;
    dly_d = s2_q;
  end

  // Synchronizer and delay registers, cleared on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      dly_q <= 1'b0;
    end else begin
      s1_q  <= s1_d;
      s2_q  <= s2_d;
      dly_q <= dly_d;
    end
  end

  // Both rising and falling transitions count as an edge.
  assign edge_pulse = s2_q ^ dly_q;

endmodule

// File: rtl/div_detector.sv
// Measures the half-period of a toggling input in clk cycles and recovers the
// divider setting (half-period - 1), with lock, timeout and range reporting
// and a valid/ack handshake for the recovered value.
module div_detector
  import div_detector_pkg::*;
#(
  parameter int DIV_W      = DIV_W_DEF,
  parameter int CNT_W      = CNT_W_DEF,
  parameter int LOCK_COUNT = LOCK_COUNT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  input  logic             meas_ack,
  output logic [DIV_W-1:0] div_out,
  output logic             meas_valid,
  output logic             overrun,
  output logic             locked,
  output logic             no_signal,
  output logic             range_err
);

  localparam logic [CNT_W-1:0] CNT_LIMIT = '1;
  localparam logic [CNT_W-1:0] H_LIMIT   = CNT_W'(2 ** DIV_W);
  localparam int               MATCH_W   = $clog2(LOCK_COUNT + 1);

  logic               sig_edge;
  logic               timeout;
  logic               h_in_range;
  logic               lock_event;
  logic [MATCH_W-1:0] match_inc;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   ref_q, ref_d;
  logic [MATCH_W-1:0] match_q, match_d;
  logic               locked_q, locked_d;
  logic               no_signal_q, no_signal_d;
  logic               range_err_q, range_err_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic               valid_q, valid_d;
  logic               overrun_q, overrun_d;

  sync_edge_det u_sync (
    .clk        (clk),
    .rst        (rst),
    .sig_in     (sig_in),
    .edge_pulse (sig_edge)
  );

  // cnt_q on an edge is the captured half-period H (cycles since last edge).
  assign h_in_range = (cnt_q <= H_LIMIT);
  assign match_inc  = match_q + 1'b1;
  assign timeout    = (state_q != S_IDLE) && !sig_edge && (cnt_q == CNT_LIMIT);

  // Half-period counter: restart at 1 on each edge, otherwise count up and saturate.
  always_comb begin
    cnt_d = cnt_q;
    if (sig_edge) begin
      cnt_d = CNT_W'(1);
    end else if (cnt_q != CNT_LIMIT) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Lock FSM: discard the first partial interval, then count matching half-periods.
  always_comb begin
    state_d     = state_q;
    ref_d       = ref_q;
    match_d     = match_q;
    locked_d    = locked_q;
    no_signal_d = no_signal_q;
    range_err_d = range_err_q;
    lock_event  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (sig_edge) begin
          state_d     = S_FIRST;
          no_signal_d = 1'b0;
        end
      end
      S_FIRST: begin
        if (sig_edge) begin
          ref_d   = cnt_q;
          match_d = MATCH_W'(1);
          state_d = S_TRACK;
        end
      end
      S_TRACK: begin
        if (sig_edge) begin
          if ((cnt_q == ref_q) && h_in_range) begin
            match_d = match_inc;
            if (match_inc == MATCH_W'(LOCK_COUNT)) begin
              state_d    = S_LOCKED;
              locked_d   = 1'b1;
              lock_event = 1'b1;
            end
          end else begin
            ref_d   = cnt_q;
            match_d = MATCH_W'(1);
          end
        end
      end
      S_LOCKED: begin
        if (sig_edge && (cnt_q != ref_q)) begin
          locked_d = 1'b0;
          ref_d    = cnt_q;
          match_d  = MATCH_W'(1);
          state_d  = S_TRACK;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Every measured half-period refreshes the range flag; the idle partial one does not.
    if (sig_edge && (state_q != S_IDLE)) begin
      range_err_d = !h_in_range;
    end

    // Lost signal: fall back to idle but keep the last recovered value.
    if (timeout) begin
      state_d     = S_IDLE;
      locked_d    = 1'b0;
      no_signal_d = 1'b1;
    end
  end

  // Result handshake: a fresh lock beats a simultaneous ack; unacked overwrite is flagged.
  always_comb begin
    div_d     = div_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    if (lock_event) begin
      div_d   = DIV_W'(cnt_q - CNT_W'(1));
      valid_d = 1'b1;
      if (valid_q && !meas_ack) begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && meas_ack) begin
      valid_d   = 1'b0;
      overrun_d = 1'b0;
    end
  end

  // State registers with synchronous reset; reset abandons any partial measurement.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      ref_q       <= '0;
      match_q     <= '0;
      locked_q    <= 1'b0;
      no_signal_q <= 1'b1;
      range_err_q <= 1'b0;
      div_q       <= '0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ref_q       <= ref_d;
      match_q     <= match_d;
      locked_q    <= locked_d;
      no_signal_q <= no_signal_d;
      range_err_q <= range_err_d;
      div_q       <= div_d;
      valid_q     <= valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign div_out    = div_q;
  assign meas_valid = valid_q;
  assign overrun    = overrun_q;
  assign locked     = locked_q;
  assign no_signal  = no_signal_q;
  assign range_err  = range_err_q;

endmodule

// File: tb/tb_div_detector.sv
// Bench for div_detector: directed scenarios plus randomized toggling, with a
// run-length reference model of half-periods checked every cycle.
module tb_div_detector;
  import div_detector_pkg::*;

  localparam int LOCKN = LOCK_COUNT_DEF;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 sig_in = 1'b0;
  logic                 meas_ack = 1'b0;
  logic [DIV_W_DEF-1:0] div_out;
  logic                 meas_valid, overrun, locked, no_signal, range_err;

  div_detector dut (
    .clk        (clk),
    .rst        (rst),
    .sig_in     (sig_in),
    .meas_ack   (meas_ack),
    .div_out    (div_out),
    .meas_valid (meas_valid),
    .overrun    (overrun),
    .locked     (locked),
    .no_signal  (no_signal),
    .range_err  (range_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model state: half-periods are tracked as a run of equal legal values.
  bit m_ready = 0;
  bit m_active = 0;
  int last_edge = 0;
  int run_val = 0;
  int run_len = 0;
  int m_div = 0;
  bit m_mv = 0, m_ov = 0, m_ns = 1, m_rerr = 0;
  bit sq[$];

  int ack_cd = 0;
  bit rand_ack = 0;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clk of the reference model; an input change is seen by the detector
  // two edges after it is sampled (synchronizer latency).
  task automatic model_step();
    bit e;
    bit ev;
    bit ack_s;
    int h;
    if (rst) begin
      m_ready = 1; m_active = 0; run_len = 0;
      m_mv = 0; m_ov = 0; m_ns = 1; m_rerr = 0; m_div = 0;
      sq = '{1'b0, 1'b0, 1'b0};
      return;
    end
    e = (sq[0] != sq[1]);
    sq.push_back(sig_in);
    void'(sq.pop_front());
    ack_s = meas_ack;
    ev = 0;
    h = 0;
    if (e) begin
      if (!m_active) begin
        m_active = 1; m_ns = 0; run_len = 0;
      end else begin
        h = cyc - last_edge;
        if (h > CNT_MAX) h = CNT_MAX;
        m_rerr = (h > H_MAX);
        if (h <= H_MAX) begin
          if (run_len > 0 && h == run_val) run_len++;
          else begin run_val = h; run_len = 1; end
        end else begin
          run_len = 0;
        end
        ev = (run_len == LOCKN);
      end
      last_edge = cyc;
    end else if (m_active && (cyc - last_edge) >= CNT_MAX) begin
      m_active = 0; m_ns = 1; run_len = 0;
    end
    if (ev) begin
      if (m_mv && !ack_s) m_ov = 1;
      m_mv = 1;
      m_div = (h - 1) % H_MAX;
    end else if (ack_s && m_mv) begin
      m_mv = 0; m_ov = 0;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      model_step();
    end
  end

  // Compare every output against the model once per cycle, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (m_ready) begin
        check("div_out",    int'(div_out),    m_div);
        check("meas_valid", int'(meas_valid), int'(m_mv));
        check("overrun",    int'(overrun),    int'(m_ov));
        check("locked",     int'(locked),     int'(run_len >= LOCKN));
        check("no_signal",  int'(no_signal),  int'(m_ns));
        check("range_err",  int'(range_err),  int'(m_rerr));
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    meas_ack = 1'b0;
    if (ack_cd > 0) begin
      ack_cd--;
      if (ack_cd == 0) meas_ack = 1'b1;
    end
    if (rand_ack && $urandom_range(0, 5) == 0) meas_ack = 1'b1;
  endtask

  task automatic wait_n(input int k);
    repeat (k) tick();
  endtask

  // n transitions: first after first_gap cycles, then every half cycles.
  // ack_last schedules an ack on the cycle the last transition is evaluated.
  task automatic toggle(input int half, input int n, input int first_gap, input bit ack_last);
    for (int i = 0; i < n; i++) begin
      wait_n((i == 0) ? first_gap : half);
      sig_in = ~sig_in;
    end
    if (ack_last) ack_cd = 2;
    $display("toggle half=%0d n=%0d at cycle %0d", half, n, cyc);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_div"},   int'(div_out),    0);
    check({tag, "_mv"},    int'(meas_valid), 0);
    check({tag, "_ov"},    int'(overrun),    0);
    check({tag, "_lock"},  int'(locked),     0);
    check({tag, "_nosig"}, int'(no_signal),  1);
    check({tag, "_rerr"},  int'(range_err),  0);
  endtask

  initial begin
    int r, half;
    rst = 1'b1;
    wait_n(2);
    rst = 1'b0;
    check_reset_values("reset");
    $display("reset released at cycle %0d", cyc);

    // Lock at div=9: not yet after 4 transitions, locked on the 5th.
    toggle(10, 4, 10, 0);
    wait_n(3);
    check("t1_pre_lock", int'(locked), 0);
    toggle(10, 1, 7, 0);
    wait_n(3);
    check("t1_locked", int'(locked), 1);
    check("t1_mv", int'(meas_valid), 1);
    check("t1_div", int'(div_out), 9);
    check("t1_nosig", int'(no_signal), 0);
    meas_ack = 1'b1;
    wait_n(1);
    check("t1_ack_mv", int'(meas_valid), 0);

    // Period change: lock drops on first H=21, relocks after 4 matches.
    toggle(21, 1, 17, 0);
    wait_n(3);
    check("t3_unlock", int'(locked), 0);
    toggle(21, 3, 18, 0);
    wait_n(3);
    check("t3_div20", int'(div_out), 20);
    check("t3_ov0", int'(overrun), 0);
    toggle(10, 4, 7, 0);
    wait_n(3);
    check("t3_div9", int'(div_out), 9);
    check("t3_ov1", int'(overrun), 1);
    toggle(21, 4, 18, 0);
    wait_n(3);
    check("t3_relock", int'(locked), 1);
    check("t3_relock_div", int'(div_out), 20);
    check("t3_relock_mv", int'(meas_valid), 1);
    check("t3_relock_ov", int'(overrun), 1);
    meas_ack = 1'b1;
    wait_n(1);
    check("t3_ack_ov", int'(overrun), 0);
    check("t3_ack_mv", int'(meas_valid), 0);

    // Ack coincident with a relock while meas_valid is high.
    toggle(10, 4, 6, 0);
    wait_n(3);
    check("t6_pre_mv", int'(meas_valid), 1);
    toggle(21, 4, 18, 1);
    wait_n(3);
    check("t6_coinc_mv", int'(meas_valid), 1);
    check("t6_coinc_ov", int'(overrun), 0);
    check("t6_coinc_div", int'(div_out), 20);

    // Timeout after 255 quiet cycles; value held; relock after 5 transitions.
    toggle(10, 4, 7, 0);
    wait_n(3);
    check("t4_div9", int'(div_out), 9);
    meas_ack = 1'b1;
    wait_n(1);
    wait_n(253);
    check("t4_before_to_nosig", int'(no_signal), 0);
    check("t4_before_to_lock", int'(locked), 1);
    wait_n(1);
    check("t4_to_nosig", int'(no_signal), 1);
    check("t4_to_lock", int'(locked), 0);
    check("t4_to_div", int'(div_out), 9);
    toggle(10, 5, 10, 0);
    wait_n(3);
    check("t4_relock", int'(locked), 1);
    check("t4_relock_div", int'(div_out), 9);

    // Boundary half-periods: 1 and 128.
    toggle(1, 5, 1, 0);
    wait_n(3);
    check("t2_lock1", int'(locked), 1);
    check("t2_div0", int'(div_out), 0);
    toggle(128, 4, 125, 0);
    wait_n(3);
    check("t2_lock128", int'(locked), 1);
    check("t2_div127", int'(div_out), 127);
    check("t2_rerr0", int'(range_err), 0);

    // Reset while locked with a pending measurement.
    check("t6_pre_rst_mv", int'(meas_valid), 1);
    rst = 1'b1;
    sig_in = 1'b0;
    wait_n(1);
    rst = 1'b0;
    check_reset_values("t6_rst");

    // Out-of-range half-period: flagged on the 2nd transition, never locks.
    toggle(200, 1, 200, 0);
    wait_n(3);
    check("t5_rerr_first", int'(range_err), 0);
    toggle(200, 1, 197, 0);
    wait_n(3);
    check("t5_rerr", int'(range_err), 1);
    toggle(200, 4, 197, 0);
    wait_n(3);
    check("t5_nolock", int'(locked), 0);
    check("t5_nomv", int'(meas_valid), 0);
    check("t5_rerr_hold", int'(range_err), 1);

    // Randomized periods, pauses, acks and resets against the model.
    rand_ack = 1;
    for (int it = 0; it < 25; it++) begin
      r = $urandom_range(0, 9);
      if (r < 6) half = $urandom_range(1, 24);
      else if (r < 9) half = $urandom_range(100, 140);
      else half = 0;
      if (half == 0) begin
        wait_n($urandom_range(200, 300));
        $display("pause ended at cycle %0d", cyc);
      end else begin
        toggle(half, $urandom_range(1, 7), half, 0);
      end
      if ($urandom_range(0, 19) == 0) begin
        rst = 1'b1;
        wait_n(1);
        rst = 1'b0;
        $display("random reset at cycle %0d", cyc);
      end
    end
    rand_ack = 0;
    wait_n(5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
